subleq64_loader: RTL and testbench
==================================

// Module: subleq64_loader
// PURPOSE
//  Boot loader upstream of the subleq64 core. Takes a byte stream over a
//  valid/ready handshake and assembles it into 64-bit words.
//  Writes the words into the core's 8K-word program memory through that
//  memory's write port, holding the core in reset while it does so.
//  Releases the core only after the stream's checksum has been verified.
// PARAMETERS
//  ADDR_W  13  word-address width of program memory (capacity 2**ADDR_W)
//  DATA_W  64  memory word width; must be a multiple of 8
// PORTS
//  iClock       in   1       single clock, rising edge
//  iReset       in   1       synchronous, active-high reset
//  iByte        in   8       stream byte
//  iByteValid   in   1       iByte is valid this cycle
//  oByteReady   out  1       loader accepts the byte; transfer = valid & ready
//  oMemAddr     out  ADDR_W  memory write word address
//  oMemData     out  DATA_W  memory write data
//  oMemWe       out  1       memory write enable, one-cycle pulse per word
//  oCoreReset   out  1       hold subleq64 in reset while high
//  oDone        out  1       image loaded and checksum verified
//  oError       out  1       load aborted
// BEHAVIOUR
//  Stream format:
//   - CNT_LO, CNT_HI: 16-bit word count N, little-endian.
//   - N*(DATA_W/8) data bytes, each word little-endian (byte 0 -> bits [7:0]).
//   - One checksum byte C. XOR of every stream byte, including C, must be 0.
//  Reset values:
//   - oByteReady=1, oMemWe=0, oMemAddr=0, oMemData=0.
//   - oCoreReset=1, oDone=0, oError=0, state=S_CNT_LO.
//  States and transitions (each transition on an accepted byte):
//   - S_CNT_LO -> S_CNT_HI.
//   - S_CNT_HI:
//      - N > 2**ADDR_W -> S_ERR.
//      - N == 0 -> S_CSUM.
//      - otherwise -> S_DATA.
//   - S_DATA: byte lane counter 0..DATA_W/8-1.
//      - The last lane completes a word.
//      - After the last byte of word N-1 -> S_CSUM.
//   - S_CSUM:
//      - running XOR ^ byte == 0 -> S_DONE.
//      - otherwise -> S_ERR.
//   - S_DONE: oByteReady=0, oCoreReset=0, oDone=1. Remains here until iReset.
//   - S_ERR: oByteReady=0, oCoreReset=1, oError=1. Remains here until iReset.
//  oByteReady is 1 in S_CNT_LO, S_CNT_HI, S_DATA and S_CSUM. There is no
//   backpressure while loading: one byte per cycle is accepted continuously.
//  Memory write timing:
//   - Completing a word in cycle t loads oMemData and oMemAddr = word index.
//   - oMemWe=1 in cycle t+1 only.
//   - The assembly register is separate from oMemData, so the byte accepted
//     in cycle t+1 does not disturb the write in progress.
//  Word index starts at 0 and increments after each write. It never wraps,
//   because N <= 2**ADDR_W.
//  The running XOR covers every accepted byte. It clears on iReset.
//  Byte gaps (valid low) are allowed in any state; no state changes on them.
//  Reset mid-load:
//   - Abandons the partial word; no oMemWe pulse follows.
//   - Returns to reset values.
//   - Already written memory words are not scrubbed.
//  oCoreReset falls in the same cycle oDone rises. That is at least one cycle
//   after the last oMemWe, since the checksum byte follows the last data byte.
// STRUCTURE
//  Shared package subleq64_pkg:
//   - SUBLEQ_ADDR_W = 13 and SUBLEQ_DATA_W = 64.
//   - Loader state encoding: S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR.
//  One natural sub-module: subleq64_byte_packer. It holds the lane counter and
//   the assembly register, and outputs word + word_valid.
//  The FSM, word counter and checksum live in the top. Top-level wiring muxes
//   the memory address/data/wren between loader (oCoreReset=1) and core.
// TESTING
//  1. N=1, data bytes 01..08, valid checksum
//     -> one oMemWe, oMemAddr=0, oMemData=64'h0807060504030201
//     -> oDone=1, oCoreReset=0.
//  2. N=3 with random words, one idle gap cycle between every byte
//     -> writes at addresses 0, 1, 2 with the matching data, then oDone.
//  3. N=2 with checksum byte XORed by 8'h01
//     -> both words are written, then oError=1, oCoreReset stays 1,
//        oByteReady=0.
//  4. Count 16'h2001 (8193)
//     -> S_ERR right after CNT_HI, no oMemWe ever.
//     Count 16'h0000 with checksum 00 -> oDone, no writes.
//  5. iReset after 5 bytes of word 1 (N=4)
//     -> no further oMemWe, outputs at reset values.
//     Reload of N=1 -> word written at address 0, oDone.
//  6. Full 8192-word image streamed back-to-back
//     -> 8192 writes, last at oMemAddr=13'h1FFF, oMemWe never on two
//        consecutive cycles, oDone.

Source files
------------

// File: rtl/subleq64_pkg.sv
// subleq64_pkg: shared memory geometry and loader state encoding for the subleq64 slice
package subleq64_pkg;
    localparam int SUBLEQ_ADDR_W = 13;
    localparam int SUBLEQ_DATA_W = 64;
    typedef enum logic [2:0] {S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR} loader_state_t;
endpackage

// File: rtl/subleq64_byte_packer.sv
// subleq64_byte_packer: gathers little-endian bytes into a DATA_W word
//  iClock/iReset  clock, synchronous active-high reset
//  data, take     byte and its accept strobe
//  word           completed word, valid in the cycle of the last lane's byte
//  word_valid     combinational pulse with the last lane's byte
module subleq64_byte_packer
    import subleq64_pkg::*;
#(
    parameter int DATA_W = SUBLEQ_DATA_W
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [7:0]        data,
    input  logic              take,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);
    localparam int LANES = DATA_W / 8;
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    logic [LW-1:0] lane;
    logic [DATA_W-9:0] asm_q;
    logic last;
    assign last = lane == LW'(LANES - 1);
    // the top lane is never stored: it goes straight into the word beside the held lanes
    assign word = {data, asm_q};
    assign word_valid = take && last;
    always_ff @(posedge iClock) begin
        if (iReset) begin
            lane <= '0;
            asm_q <= '0;
        end else if (take) begin
            lane <= last ? '0 : lane + 1'b1;
            if (!last) asm_q[{lane, 3'b000} +: 8] <= data;
        end
    end
endmodule

// File: rtl/subleq64_loader.sv
// subleq64_loader: streams a checksummed byte image into program memory, holding the core in reset
//  iClock/iReset          clock, synchronous active-high reset
//  iByte/iByteValid       stream byte and valid; oByteReady accepts it
//  oMemAddr/Data/We       program memory write port, one-cycle We per word
//  oCoreReset             holds the core in reset until the image is verified
//  oDone/oError           image verified / load aborted
module subleq64_loader
    import subleq64_pkg::*;
#(
    parameter int ADDR_W = SUBLEQ_ADDR_W,
    parameter int DATA_W = SUBLEQ_DATA_W
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [7:0]        iByte,
    input  logic              iByteValid,
    output logic              oByteReady,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemData,
    output logic              oMemWe,
    output logic              oCoreReset,
    output logic              oDone,
    output logic              oError
);
    localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);
    loader_state_t state;
    logic [7:0] cnt_lo, csum;
    logic [15:0] cnt, wcnt;
    logic [DATA_W-1:0] word;
    logic word_valid, take;
    assign take = iByteValid && oByteReady;
    subleq64_byte_packer #(.DATA_W(DATA_W)) packer (
        .iClock(iClock),
        .iReset(iReset),
        .data(iByte),
        .take(take && state == S_DATA),
        .word(word),
        .word_valid(word_valid)
    );
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state <= S_CNT_LO;
            oByteReady <= 1'b1;
            oMemWe <= 1'b0;
            oMemAddr <= '0;
            oMemData <= '0;
            oCoreReset <= 1'b1;
            oDone <= 1'b0;
            oError <= 1'b0;
            cnt_lo <= '0;
            csum <= '0;
            cnt <= '0;
            wcnt <= '0;
        end else begin
            oMemWe <= word_valid;
            if (word_valid) begin
                oMemData <= word;
                oMemAddr <= wcnt[ADDR_W-1:0];
                wcnt <= wcnt + 16'd1;
            end
            if (take) begin
                csum <= csum ^ iByte;
                case (state)
                    S_CNT_LO: begin
                        cnt_lo <= iByte;
                        state <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        cnt <= {iByte, cnt_lo};
                        if ({1'b0, iByte, cnt_lo} > MAX_N) begin
                            state <= S_ERR;
                            oByteReady <= 1'b0;
                            oError <= 1'b1;
                        end else begin
                            state <= {iByte, cnt_lo} == 16'd0 ? S_CSUM : S_DATA;
                        end
                    end
                    S_DATA: if (word_valid && wcnt == cnt - 16'd1) state <= S_CSUM;
                    S_CSUM: begin
                        oByteReady <= 1'b0;
                        if ((csum ^ iByte) == 8'd0) begin
                            state <= S_DONE;
                            oCoreReset <= 1'b0;
                            oDone <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            oError <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_subleq64_loader.sv
// tb_subleq64_loader: directed checks of the subleq64 boot loader
module tb_subleq64_loader;
    logic iClock = 1'b0;
    logic iReset = 1'b1;
    logic [7:0] iByte = '0;
    logic iByteValid = 1'b0;
    logic oByteReady, oMemWe, oCoreReset, oDone, oError;
    logic [12:0] oMemAddr;
    logic [63:0] oMemData;
    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int dbl = 0;
    logic prev_we = 1'b0;
    logic [12:0] wa [0:16383];
    logic [63:0] wd [0:16383];
    logic [7:0] x;
    logic [63:0] exp_w [0:2];
    subleq64_loader dut (
        .iClock(iClock),
        .iReset(iReset),
        .iByte(iByte),
        .iByteValid(iByteValid),
        .oByteReady(oByteReady),
        .oMemAddr(oMemAddr),
        .oMemData(oMemData),
        .oMemWe(oMemWe),
        .oCoreReset(oCoreReset),
        .oDone(oDone),
        .oError(oError)
    );
    always #5 iClock = ~iClock;
    always @(negedge iClock) begin
        if (oMemWe) begin
            wa[wr_total] = oMemAddr;
            wd[wr_total] = oMemData;
            wr_total = wr_total + 1;
            if (prev_we) dbl = dbl + 1;
        end
        prev_we = oMemWe;
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        iByte = b;
        iByteValid = 1'b1;
        x = x ^ b;
        @(negedge iClock);
        iByteValid = 1'b0;
    endtask
    task automatic send_word(input logic [63:0] w, input bit gap);
        for (int i = 0; i < 8; i++) begin
            send(w[8*i +: 8]);
            if (gap) @(negedge iClock);
        end
    endtask
    task automatic do_reset();
        iReset = 1'b1;
        iByteValid = 1'b0;
        @(negedge iClock);
        iReset = 1'b0;
        x = 8'h00;
    endtask
    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(oByteReady), 64'd1);
        check({tag, "_we"}, 64'(oMemWe), 64'd0);
        check({tag, "_addr"}, 64'(oMemAddr), 64'd0);
        check({tag, "_data"}, oMemData, 64'd0);
        check({tag, "_corerst"}, 64'(oCoreReset), 64'd1);
        check({tag, "_done"}, 64'(oDone), 64'd0);
        check({tag, "_err"}, 64'(oError), 64'd0);
    endtask
    initial begin
        int base, bad;
        logic [63:0] w;
        x = 8'h00;
        @(negedge iClock);
        @(negedge iClock);
        check_reset_vals("rst");
        iReset = 1'b0;
        // 1: single word 01..08, checksum 01^00^(01..08) = 09
        base = wr_total;
        send(8'h01); send(8'h00);
        send_word(64'h0807060504030201, 1'b0);
        check("t1_csum_model", 64'(x), 64'h09);
        send(8'h09);
        check("t1_nwr", 64'(wr_total - base), 64'd1);
        check("t1_addr", 64'(wa[base]), 64'd0);
        check("t1_data", wd[base], 64'h0807060504030201);
        check("t1_done", 64'(oDone), 64'd1);
        check("t1_corerst", 64'(oCoreReset), 64'd0);
        check("t1_ready", 64'(oByteReady), 64'd0);
        check("t1_err", 64'(oError), 64'd0);
        // 2: three random words, idle gap after every byte
        do_reset();
        base = wr_total;
        for (int i = 0; i < 3; i++) exp_w[i] = {$urandom, $urandom};
        send(8'h03); @(negedge iClock);
        send(8'h00); @(negedge iClock);
        for (int i = 0; i < 3; i++) send_word(exp_w[i], 1'b1);
        send(x);
        check("t2_nwr", 64'(wr_total - base), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_addr%0d", i), 64'(wa[base+i]), 64'(i));
            check($sformatf("t2_data%0d", i), wd[base+i], exp_w[i]);
        end
        check("t2_done", 64'(oDone), 64'd1);
        check("t2_dbl", 64'(dbl), 64'd0);
        // 3: two words with a corrupted checksum
        do_reset();
        base = wr_total;
        send(8'h02); send(8'h00);
        send_word(64'h1122334455667788, 1'b0);
        send_word(64'hA5A5_0000_FFFF_5A5A, 1'b0);
        send(x ^ 8'h01);
        check("t3_nwr", 64'(wr_total - base), 64'd2);
        check("t3_data1", wd[base+1], 64'hA5A5_0000_FFFF_5A5A);
        check("t3_err", 64'(oError), 64'd1);
        check("t3_corerst", 64'(oCoreReset), 64'd1);
        check("t3_ready", 64'(oByteReady), 64'd0);
        check("t3_done", 64'(oDone), 64'd0);
        // 4a: oversized count 8193
        do_reset();
        base = wr_total;
        send(8'h01); send(8'h20);
        check("t4_err", 64'(oError), 64'd1);
        check("t4_ready", 64'(oByteReady), 64'd0);
        repeat (4) send(8'h00);
        check("t4_nwr", 64'(wr_total - base), 64'd0);
        // 4b: empty image
        do_reset();
        base = wr_total;
        send(8'h00); send(8'h00); send(8'h00);
        check("t4b_done", 64'(oDone), 64'd1);
        check("t4b_corerst", 64'(oCoreReset), 64'd0);
        check("t4b_nwr", 64'(wr_total - base), 64'd0);
        // 5: reset five bytes into word 1 of a four-word image, then reload
        do_reset();
        base = wr_total;
        send(8'h04); send(8'h00);
        send_word(64'h0102030405060708, 1'b0);
        for (int i = 0; i < 5; i++) send(8'hEE);
        iReset = 1'b1;
        @(negedge iClock);
        check_reset_vals("t5");
        iReset = 1'b0;
        x = 8'h00;
        repeat (3) @(negedge iClock);
        check("t5_nwr", 64'(wr_total - base), 64'd1);
        base = wr_total;
        send(8'h01); send(8'h00);
        send_word(64'hCAFEF00D_DEADBEEF, 1'b0);
        send(x);
        check("t5_nwr2", 64'(wr_total - base), 64'd1);
        check("t5_addr", 64'(wa[base]), 64'd0);
        check("t5_data", wd[base], 64'hCAFEF00D_DEADBEEF);
        check("t5_done", 64'(oDone), 64'd1);
        // 6: full 8192-word image back-to-back
        do_reset();
        base = wr_total;
        send(8'h00); send(8'h20);
        for (int i = 0; i < 8192; i++) send_word(64'(i) * 64'h9E3779B97F4A7C15, 1'b0);
        check("t6_done_early", 64'(oDone), 64'd0);
        send(x);
        check("t6_nwr", 64'(wr_total - base), 64'd8192);
        check("t6_last_addr", 64'(wa[base+8191]), 64'h1FFF);
        bad = 0;
        for (int i = 0; i < 8192; i++) begin
            w = 64'(i) * 64'h9E3779B97F4A7C15;
            if (wa[base+i] !== 13'(i) || wd[base+i] !== w) bad++;
        end
        check("t6_bad_words", 64'(bad), 64'd0);
        check("t6_dbl", 64'(dbl), 64'd0);
        check("t6_done", 64'(oDone), 64'd1);
        check("t6_corerst", 64'(oCoreReset), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
